shared_tlb_ctrl: RTL and testbench

Sequencer that shares one fully-associative SV39 TLB between an instruction requester (port 0) and a data requester (port 1). It arbitrates lookups round-robin and, on a miss, drives a page-table-walker (PTW) request. It then writes the walk result into the TLB and returns it to the owning requester. It also serialises SFENCE.VMA flushes against in-flight walks. It sits between the fetch/LSU translation front-ends and the TLB + PTW pair in the MMU.

---
 rtl/shared_tlb_ctrl_if.sv | 74 +++++++
 rtl/shared_tlb_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_shared_tlb_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_tlb_ctrl_if.sv
// Bundle of requester, TLB, PTW and SFENCE signals around the shared TLB sequencer.
// The master modport is the sequencer's view; the slave modport is its environment.
interface shared_tlb_ctrl_if #(
  parameter int unsigned ASID_WIDTH = 1,
  parameter int unsigned VLEN       = 39
);
  typedef struct packed {
    logic                  valid;
    logic                  is_2M;
    logic                  is_1G;
    logic [VLEN-13:0]      vpn;
    logic [ASID_WIDTH-1:0] asid;
    logic [63:0]           content;
  } tlb_update_t;

  logic [1:0]                 req_i;
  logic [1:0][VLEN-1:0]       vaddr_i;
  logic [ASID_WIDTH-1:0]      asid_i;
  logic [1:0]                 ack_o;
  logic [63:0]                content_o;
  logic                       is_2M_o;
  logic                       is_1G_o;
  logic                       err_o;

  logic                       tlb_access_o;
  logic [VLEN-1:0]            tlb_vaddr_o;
  logic [ASID_WIDTH-1:0]      tlb_asid_o;
  logic                       tlb_hit_i;
  logic [63:0]                tlb_content_i;
  logic                       tlb_is_2M_i;
  logic                       tlb_is_1G_i;
  tlb_update_t                tlb_update_o;
  logic                       tlb_flush_o;
  logic [ASID_WIDTH-1:0]      tlb_flush_asid_o;
  logic [VLEN-1:0]            tlb_flush_vaddr_o;

  logic                       flush_i;
  logic [ASID_WIDTH-1:0]      flush_asid_i;
  logic [VLEN-1:0]            flush_vaddr_i;
  logic                       flush_ack_o;

  logic                       ptw_req_o;
  logic [VLEN-1:0]            ptw_vaddr_o;
  logic [ASID_WIDTH-1:0]      ptw_asid_o;
  logic                       ptw_valid_i;
  logic                       ptw_err_i;
  logic [63:0]                ptw_pte_i;
  logic                       ptw_is_2M_i;
  logic                       ptw_is_1G_i;

  modport master (
    input  req_i, vaddr_i, asid_i,
    output ack_o, content_o, is_2M_o, is_1G_o, err_o,
    output tlb_access_o, tlb_vaddr_o, tlb_asid_o,
    input  tlb_hit_i, tlb_content_i, tlb_is_2M_i, tlb_is_1G_i,
    output tlb_update_o, tlb_flush_o, tlb_flush_asid_o, tlb_flush_vaddr_o,
    input  flush_i, flush_asid_i, flush_vaddr_i,
    output flush_ack_o,
    output ptw_req_o, ptw_vaddr_o, ptw_asid_o,
    input  ptw_valid_i, ptw_err_i, ptw_pte_i, ptw_is_2M_i, ptw_is_1G_i
  );

  modport slave (
    output req_i, vaddr_i, asid_i,
    input  ack_o, content_o, is_2M_o, is_1G_o, err_o,
    input  tlb_access_o, tlb_vaddr_o, tlb_asid_o,
    output tlb_hit_i, tlb_content_i, tlb_is_2M_i, tlb_is_1G_i,
    input  tlb_update_o, tlb_flush_o, tlb_flush_asid_o, tlb_flush_vaddr_o,
    output flush_i, flush_asid_i, flush_vaddr_i,
    input  flush_ack_o,
    input  ptw_req_o, ptw_vaddr_o, ptw_asid_o,
    output ptw_valid_i, ptw_err_i, ptw_pte_i, ptw_is_2M_i, ptw_is_1G_i
  );
endinterface

// File: rtl/shared_tlb_ctrl.sv
// Shares one SV39 TLB between fetch (port 0) and LSU (port 1): round-robin lookups,
// PTW refill on miss, and SFENCE.VMA flushes serialised behind any in-flight walk.
module shared_tlb_ctrl #(
  parameter int unsigned ASID_WIDTH = 1,
  parameter int unsigned VLEN       = 39
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  shared_tlb_ctrl_if.master       bus
);
  localparam int unsigned VPN_W = VLEN - 12;

  typedef enum logic [1:0] {IDLE, WALK, RESP, FLUSH} state_e;

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  owner_q, owner_d;
  logic [VLEN-1:0]       walk_vaddr_q, walk_vaddr_d;
  logic [ASID_WIDTH-1:0] walk_asid_q, walk_asid_d;
  logic [1:0]            ack_q, ack_d;
  logic [63:0]           content_q, content_d;
  logic                  is_2M_q, is_2M_d;
  logic                  is_1G_q, is_1G_d;
  logic                  err_q, err_d;
  logic                  upd_valid_q, upd_valid_d;
  logic                  upd_2M_q, upd_2M_d;
  logic                  upd_1G_q, upd_1G_d;
  logic [VPN_W-1:0]      upd_vpn_q, upd_vpn_d;
  logic [ASID_WIDTH-1:0] upd_asid_q, upd_asid_d;
  logic [63:0]           upd_content_q, upd_content_d;
  logic                  tlb_flush_q, tlb_flush_d;
  logic                  flush_ack_q, flush_ack_d;
  logic                  ptw_req_q, ptw_req_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [ASID_WIDTH-1:0] flush_asid_q, flush_asid_d;
  logic [VLEN-1:0]       flush_vaddr_q, flush_vaddr_d;

  logic [1:0]            elig;
  logic                  grant;
  logic                  gnt_idx;

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    owner_d       = owner_q;
    walk_vaddr_d  = walk_vaddr_q;
    walk_asid_d   = walk_asid_q;
    ack_d         = '0;
    content_d     = content_q;
    is_2M_d       = is_2M_q;
    is_1G_d       = is_1G_q;
    err_d         = err_q;
    upd_valid_d   = 1'b0;
    upd_2M_d      = upd_2M_q;
    upd_1G_d      = upd_1G_q;
    upd_vpn_d     = upd_vpn_q;
    upd_asid_d    = upd_asid_q;
    upd_content_d = upd_content_q;
    ptw_req_d     = 1'b0;
    flush_pend_d  = flush_pend_q;
    flush_asid_d  = flush_asid_q;
    flush_vaddr_d = flush_vaddr_q;
    grant         = 1'b0;
    // A requester whose ack is on the wire this cycle must not be granted again.
    elig          = bus.req_i & ~ack_q;
    gnt_idx       = elig[rr_q] ? rr_q : ~rr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.flush_i || flush_pend_q) begin
          state_d = FLUSH;
        end else if ((|elig) && rst_ni) begin
          grant = 1'b1;
          rr_d  = ~gnt_idx;
          if (bus.tlb_hit_i) begin
            ack_d[gnt_idx] = 1'b1;
            content_d      = bus.tlb_content_i;
            is_2M_d        = bus.tlb_is_2M_i;
            is_1G_d        = bus.tlb_is_1G_i;
            err_d          = 1'b0;
          end else begin
            owner_d      = gnt_idx;
            walk_vaddr_d = bus.vaddr_i[gnt_idx];
            walk_asid_d  = bus.asid_i;
            ptw_req_d    = 1'b1;
            state_d      = WALK;
          end
        end
      end
      WALK: begin
        if (bus.ptw_valid_i) begin
          ack_d[owner_q] = 1'b1;
          content_d      = bus.ptw_pte_i;
          is_2M_d        = bus.ptw_is_2M_i;
          is_1G_d        = bus.ptw_is_1G_i;
          err_d          = bus.ptw_err_i;
          // A flush arriving with the result also counts as pending: never refill stale state.
          upd_valid_d    = !bus.ptw_err_i && !flush_pend_q && !bus.flush_i;
          upd_2M_d       = bus.ptw_is_2M_i;
          upd_1G_d       = bus.ptw_is_1G_i;
          upd_vpn_d      = walk_vaddr_q[VLEN-1:12];
          upd_asid_d     = walk_asid_q;
          upd_content_d  = bus.ptw_pte_i;
          state_d        = RESP;
        end
      end
      RESP: state_d = flush_pend_q ? FLUSH : IDLE;
      FLUSH: begin
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush_i) begin
      flush_pend_d  = 1'b1;
      flush_asid_d  = bus.flush_asid_i;
      flush_vaddr_d = bus.flush_vaddr_i;
    end

    tlb_flush_d = (state_d == FLUSH);
    flush_ack_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      rr_q          <= 1'b0;
      owner_q       <= 1'b0;
      walk_vaddr_q  <= '0;
      walk_asid_q   <= '0;
      ack_q         <= '0;
      content_q     <= '0;
      is_2M_q       <= 1'b0;
      is_1G_q       <= 1'b0;
      err_q         <= 1'b0;
      upd_valid_q   <= 1'b0;
      upd_2M_q      <= 1'b0;
      upd_1G_q      <= 1'b0;
      upd_vpn_q     <= '0;
      upd_asid_q    <= '0;
      upd_content_q <= '0;
      tlb_flush_q   <= 1'b0;
      flush_ack_q   <= 1'b0;
      ptw_req_q     <= 1'b0;
      flush_pend_q  <= 1'b0;
      flush_asid_q  <= '0;
      flush_vaddr_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      walk_vaddr_q  <= walk_vaddr_d;
      walk_asid_q   <= walk_asid_d;
      ack_q         <= ack_d;
      content_q     <= content_d;
      is_2M_q       <= is_2M_d;
      is_1G_q       <= is_1G_d;
      err_q         <= err_d;
      upd_valid_q   <= upd_valid_d;
      upd_2M_q      <= upd_2M_d;
      upd_1G_q      <= upd_1G_d;
      upd_vpn_q     <= upd_vpn_d;
      upd_asid_q    <= upd_asid_d;
      upd_content_q <= upd_content_d;
      tlb_flush_q   <= tlb_flush_d;
      flush_ack_q   <= flush_ack_d;
      ptw_req_q     <= ptw_req_d;
      flush_pend_q  <= flush_pend_d;
      flush_asid_q  <= flush_asid_d;
      flush_vaddr_q <= flush_vaddr_d;
    end
  end

  assign bus.ack_o             = ack_q;
  assign bus.content_o         = content_q;
  assign bus.is_2M_o           = is_2M_q;
  assign bus.is_1G_o           = is_1G_q;
  assign bus.err_o             = err_q;
  assign bus.tlb_access_o      = grant;
  assign bus.tlb_vaddr_o       = grant ? bus.vaddr_i[gnt_idx] : '0;
  assign bus.tlb_asid_o        = grant ? bus.asid_i : '0;
  assign bus.tlb_update_o      = {upd_valid_q, upd_2M_q, upd_1G_q, upd_vpn_q, upd_asid_q, upd_content_q};
  assign bus.tlb_flush_o       = tlb_flush_q;
  assign bus.tlb_flush_asid_o  = flush_asid_q;
  assign bus.tlb_flush_vaddr_o = flush_vaddr_q;
  assign bus.flush_ack_o       = flush_ack_q;
  assign bus.ptw_req_o         = ptw_req_q;
  assign bus.ptw_vaddr_o       = walk_vaddr_q;
  assign bus.ptw_asid_o        = walk_asid_q;
endmodule

// File: tb/tb_shared_tlb_ctrl.sv
// Bench for shared_tlb_ctrl: directed timing cases, then randomized traffic against
// a page-table / TLB-contents model that checks every ack, refill, walk and flush.
module tb_shared_tlb_ctrl;
  localparam int AW = 1;
  localparam int VL = 39;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shared_tlb_ctrl_if #(.ASID_WIDTH(AW), .VLEN(VL)) bus ();
  shared_tlb_ctrl #(.ASID_WIDTH(AW), .VLEN(VL)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  function automatic logic [26:0] vpn_of(input int i);
    case (i)
      0: return 27'h0000010;
      1: return 27'h1234567;
      2: return 27'h7FFFFFF;
      3: return 27'h0ABCDEF;
      4: return 27'h5555555;
      default: return 27'h2AAAAAA;
    endcase
  endfunction

  function automatic int idx_of(input logic [26:0] vpn);
    for (int i = 0; i < 6; i++) if (vpn_of(i) == vpn) return i;
    return -1;
  endfunction

  function automatic logic [63:0] pte_of(input int i);
    if (i < 0) return 64'h0;
    return {10'b0, 44'h80000 + 44'(i * 4099), 10'h0CF};
  endfunction

  function automatic bit is_fault(input int i); return i == 5; endfunction
  function automatic bit is2m(input int i);     return i == 2; endfunction
  function automatic bit is1g(input int i);     return i == 3; endfunction

  function automatic logic [63:0] ppn_pte(input logic [43:0] ppn);
    return {10'b0, ppn, 10'h0CF};
  endfunction

  task automatic clear_inputs();
    bus.req_i = '0; bus.vaddr_i = '0; bus.asid_i = '0;
    bus.tlb_hit_i = 1'b0; bus.tlb_content_i = '0; bus.tlb_is_2M_i = 1'b0; bus.tlb_is_1G_i = 1'b0;
    bus.flush_i = 1'b0; bus.flush_asid_i = '0; bus.flush_vaddr_i = '0;
    bus.ptw_valid_i = 1'b0; bus.ptw_err_i = 1'b0; bus.ptw_pte_i = '0;
    bus.ptw_is_2M_i = 1'b0; bus.ptw_is_1G_i = 1'b0;
  endtask

  task automatic do_reset();
    nxt(); clear_inputs(); rst_n = 1'b0;
    nxt(); nxt(); rst_n = 1'b1;
  endtask

  // Miss on one port; optional fault and optional SFENCE while the walk is running.
  task automatic miss_seq(input bit port, input logic [38:0] va, input bit perr, input bit fmid);
    logic [1:0] own;
    own = port ? 2'b10 : 2'b01;
    nxt(); bus.req_i[port] = 1'b1; bus.vaddr_i[port] = va; bus.tlb_hit_i = 1'b0;
    #1 chk("miss_access", 64'(bus.tlb_access_o), 64'd1);
    nxt(); chk("miss_ptw_req", 64'(bus.ptw_req_o), 64'd1);
    chk("miss_ptw_vaddr", 64'(bus.ptw_vaddr_o), 64'(va));
    if (fmid) begin bus.flush_i = 1'b1; bus.flush_asid_i = '0; bus.flush_vaddr_i = '0; end
    nxt(); bus.flush_i = 1'b0;
    chk("miss_ptw_req_once", 64'(bus.ptw_req_o), 64'd0);
    nxt(); nxt(); nxt();
    chk("miss_wait_no_ack", 64'(bus.ack_o), 64'd0);
    bus.ptw_valid_i = 1'b1; bus.ptw_err_i = perr; bus.ptw_pte_i = ppn_pte(44'h80000);
    bus.ptw_is_2M_i = 1'b1; bus.ptw_is_1G_i = 1'b0;
    nxt(); bus.ptw_valid_i = 1'b0; bus.ptw_err_i = 1'b0;
    chk("resp_ack", 64'(bus.ack_o), 64'(own));
    chk("resp_err", 64'(bus.err_o), 64'(perr));
    chk("resp_ppn", 64'(bus.content_o[53:10]), 64'h80000);
    chk("resp_is_2M", 64'(bus.is_2M_o), 64'd1);
    chk("resp_upd_valid", 64'(bus.tlb_update_o.valid), 64'(!perr && !fmid));
    chk("resp_no_flush", 64'(bus.tlb_flush_o), 64'd0);
    if (!perr && !fmid) begin
      chk("upd_vpn", 64'(bus.tlb_update_o.vpn), 64'(va[38:12]));
      chk("upd_2M", 64'(bus.tlb_update_o.is_2M), 64'd1);
      chk("upd_content", bus.tlb_update_o.content, ppn_pte(44'h80000));
    end
    bus.req_i[port] = 1'b0;
    nxt();
    chk("post_resp_ack", 64'(bus.ack_o), 64'd0);
    chk("post_resp_upd", 64'(bus.tlb_update_o.valid), 64'd0);
    if (fmid) begin
      chk("fmid_tlb_flush", 64'(bus.tlb_flush_o), 64'd1);
      chk("fmid_flush_ack", 64'(bus.flush_ack_o), 64'd1);
      chk("fmid_flush_asid", 64'(bus.tlb_flush_asid_o), 64'd0);
      chk("fmid_flush_vaddr", 64'(bus.tlb_flush_vaddr_o), 64'd0);
      nxt();
      chk("fmid_flush_ack_drop", 64'(bus.flush_ack_o), 64'd0);
    end
    // Requester re-presents the page: refilled entry is looked up immediately.
    bus.req_i[port] = 1'b1; bus.tlb_hit_i = 1'b1; bus.tlb_content_i = ppn_pte(44'h80000);
    #1 chk("relookup_access", 64'(bus.tlb_access_o), 64'd1);
    chk("relookup_vaddr", 64'(bus.tlb_vaddr_o), 64'(va));
    nxt(); chk("relookup_ack", 64'(bus.ack_o), 64'(own));
    bus.req_i = '0; bus.tlb_hit_i = 1'b0;
  endtask

  bit               pend [2];
  logic [38:0]      pva  [2];
  int               pidx [2];
  bit               walk_on;
  int               walk_cnt;
  int               walk_i;
  bit               fl_out;
  logic [AW-1:0]    fl_asid;
  logic [38:0]      fl_va;
  bit               mv   [6];
  bit               drain;
  bit               match;
  int               ui;
  logic [AW-1:0]    asid_run;
  logic [95:0]      rbits;

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    // Reset with noise on every input.
    for (int k = 0; k < 4; k++) begin
      nxt();
      rbits = {$urandom, $urandom, $urandom};
      bus.req_i = 2'($urandom); bus.vaddr_i = rbits[77:0]; bus.asid_i = AW'($urandom);
      bus.tlb_hit_i = 1'($urandom); bus.tlb_content_i = {$urandom, $urandom};
      bus.tlb_is_2M_i = 1'($urandom); bus.tlb_is_1G_i = 1'($urandom);
      bus.flush_i = 1'($urandom); bus.flush_asid_i = AW'($urandom); bus.flush_vaddr_i = rbits[38:0];
      bus.ptw_valid_i = 1'($urandom); bus.ptw_err_i = 1'($urandom); bus.ptw_pte_i = {$urandom, $urandom};
      bus.ptw_is_2M_i = 1'($urandom); bus.ptw_is_1G_i = 1'($urandom);
    end
    #1;
    chk("rst_ack", 64'(bus.ack_o), 64'd0);
    chk("rst_content", bus.content_o, 64'd0);
    chk("rst_size", 64'({bus.is_2M_o, bus.is_1G_o}), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_update", 64'(bus.tlb_update_o.valid), 64'd0);
    chk("rst_update_content", bus.tlb_update_o.content, 64'd0);
    chk("rst_tlb_flush", 64'(bus.tlb_flush_o), 64'd0);
    chk("rst_flush_ack", 64'(bus.flush_ack_o), 64'd0);
    chk("rst_ptw_req", 64'(bus.ptw_req_o), 64'd0);
    chk("rst_tlb_access", 64'(bus.tlb_access_o), 64'd0);
    chk("rst_ptw_vaddr", 64'(bus.ptw_vaddr_o), 64'd0);
    chk("rst_flush_vaddr", 64'(bus.tlb_flush_vaddr_o), 64'd0);

    // Release, then a hit on port 0 in the first cycle.
    nxt(); clear_inputs(); rst_n = 1'b1;
    bus.req_i = 2'b01; bus.vaddr_i[0] = 39'h0_0000_4000;
    bus.tlb_hit_i = 1'b1; bus.tlb_content_i = ppn_pte(44'h80004);
    #1 chk("hit_access", 64'(bus.tlb_access_o), 64'd1);
    chk("hit_vaddr", 64'(bus.tlb_vaddr_o), 64'h4000);
    nxt();
    chk("hit_ack", 64'(bus.ack_o), 64'b01);
    chk("hit_ppn", 64'(bus.content_o[53:10]), 64'h80004);
    chk("hit_err", 64'(bus.err_o), 64'd0);
    bus.req_i = 2'b00; bus.tlb_hit_i = 1'b0;
    nxt(); chk("hit_ack_strobe", 64'(bus.ack_o), 64'd0);

    // Both ports request out of reset.
    do_reset();
    bus.req_i = 2'b11; bus.vaddr_i[0] = 39'h0_0000_1000; bus.vaddr_i[1] = 39'h0_0000_2000;
    bus.tlb_hit_i = 1'b1; bus.tlb_content_i = ppn_pte(44'h111);
    #1 chk("cont_first_vaddr", 64'(bus.tlb_vaddr_o), 64'h1000);
    nxt(); chk("cont_ack0", 64'(bus.ack_o), 64'b01);
    chk("cont_ppn0", 64'(bus.content_o[53:10]), 64'h111);
    bus.req_i = 2'b10; bus.tlb_content_i = ppn_pte(44'h222);
    #1 chk("cont_second_vaddr", 64'(bus.tlb_vaddr_o), 64'h2000);
    nxt(); chk("cont_ack1", 64'(bus.ack_o), 64'b10);
    chk("cont_ppn1", 64'(bus.content_o[53:10]), 64'h222);
    chk("cont_rr", 64'(dut.rr_q), 64'd0);
    bus.req_i = 2'b00; bus.tlb_hit_i = 1'b0;

    miss_seq(1'b1, 39'h12_3456_7000, 1'b0, 1'b0);
    miss_seq(1'b1, 39'h12_3456_7000, 1'b1, 1'b0);
    miss_seq(1'b0, 39'h00_0ABC_D000, 1'b0, 1'b1);

    // SFENCE in IDLE blocks the grant for two cycles.
    nxt(); bus.flush_i = 1'b1; bus.flush_asid_i = 1'b1; bus.flush_vaddr_i = 39'h7F_FFFF_F000;
    bus.req_i = 2'b01; bus.vaddr_i[0] = 39'h0_0000_5000; bus.tlb_hit_i = 1'b1;
    #1 chk("fidle_no_grant0", 64'(bus.tlb_access_o), 64'd0);
    nxt(); bus.flush_i = 1'b0;
    chk("fidle_tlb_flush", 64'(bus.tlb_flush_o), 64'd1);
    chk("fidle_flush_ack", 64'(bus.flush_ack_o), 64'd1);
    chk("fidle_asid", 64'(bus.tlb_flush_asid_o), 64'd1);
    chk("fidle_vaddr", 64'(bus.tlb_flush_vaddr_o), 64'h7F_FFFF_F000);
    #1 chk("fidle_no_grant1", 64'(bus.tlb_access_o), 64'd0);
    nxt(); chk("fidle_ack_drop", 64'(bus.flush_ack_o), 64'd0);
    #1 chk("fidle_grant", 64'(bus.tlb_access_o), 64'd1);
    nxt(); chk("fidle_hit_ack", 64'(bus.ack_o), 64'b01);
    bus.req_i = 2'b00; bus.tlb_hit_i = 1'b0;

    // Reset in the middle of a walk; the late walk result is ignored.
    nxt(); bus.req_i = 2'b01; bus.vaddr_i[0] = 39'h0_0000_9000;
    nxt(); chk("rmid_ptw_req", 64'(bus.ptw_req_o), 64'd1);
    rst_n = 1'b0; bus.req_i = 2'b00;
    nxt(); rst_n = 1'b1; bus.ptw_valid_i = 1'b1; bus.ptw_pte_i = ppn_pte(44'h333);
    nxt(); bus.ptw_valid_i = 1'b0;
    chk("rmid_no_ack", 64'(bus.ack_o), 64'd0);
    chk("rmid_no_upd", 64'(bus.tlb_update_o.valid), 64'd0);

    // Randomized traffic: requesters, a TLB holding refills, a PTW with random latency.
    do_reset();
    asid_run = AW'($urandom);
    bus.asid_i = asid_run;
    for (int i = 0; i < 6; i++) mv[i] = 1'b0;
    pend[0] = 0; pend[1] = 0; walk_on = 0; fl_out = 0; walk_i = -1; walk_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drain = (cyc >= 2600);
      if (drain && !pend[0] && !pend[1] && !walk_on && !fl_out) break;
      nxt();
      for (int p = 0; p < 2; p++) begin
        if (bus.ack_o[p]) begin
          chk("rnd_ack_owner", 64'(pend[p]), 64'd1);
          chk("rnd_content", bus.content_o, pte_of(pidx[p]));
          chk("rnd_err", 64'(bus.err_o), 64'(is_fault(pidx[p])));
          chk("rnd_size", 64'({bus.is_2M_o, bus.is_1G_o}), 64'({is2m(pidx[p]), is1g(pidx[p])}));
          pend[p] = 1'b0;
        end
      end
      if (bus.tlb_update_o.valid) begin
        ui = idx_of(bus.tlb_update_o.vpn);
        chk("rnd_upd_under_flush", 64'(fl_out), 64'd0);
        chk("rnd_upd_fault", 64'(is_fault(ui)), 64'd0);
        chk("rnd_upd_content", bus.tlb_update_o.content, pte_of(ui));
        chk("rnd_upd_asid", 64'(bus.tlb_update_o.asid), 64'(asid_run));
        if (ui >= 0) mv[ui] = 1'b1;
      end
      if (bus.tlb_flush_o) begin
        chk("rnd_flush_expected", 64'(fl_out), 64'd1);
        chk("rnd_flush_ack", 64'(bus.flush_ack_o), 64'd1);
        chk("rnd_flush_asid", 64'(bus.tlb_flush_asid_o), 64'(fl_asid));
        chk("rnd_flush_vaddr", 64'(bus.tlb_flush_vaddr_o), 64'(fl_va));
        for (int i = 0; i < 6; i++) mv[i] = 1'b0;
        fl_out = 1'b0;
      end
      if (bus.ptw_req_o) begin
        chk("rnd_single_walk", 64'(walk_on), 64'd0);
        match = 1'b0;
        for (int p = 0; p < 2; p++) if (pend[p] && pva[p] == bus.ptw_vaddr_o) match = 1'b1;
        chk("rnd_walk_vaddr", 64'(match), 64'd1);
        chk("rnd_walk_asid", 64'(bus.ptw_asid_o), 64'(asid_run));
        walk_i = idx_of(bus.ptw_vaddr_o[38:12]);
        walk_on = 1'b1;
        walk_cnt = $urandom_range(0, 5);
      end
      bus.ptw_valid_i = 1'b0;
      if (walk_on) begin
        if (walk_cnt == 0) begin
          bus.ptw_valid_i = 1'b1; bus.ptw_err_i = is_fault(walk_i); bus.ptw_pte_i = pte_of(walk_i);
          bus.ptw_is_2M_i = is2m(walk_i); bus.ptw_is_1G_i = is1g(walk_i);
          walk_on = 1'b0;
        end else begin
          walk_cnt--;
        end
      end
      bus.flush_i = 1'b0;
      if (!drain && !fl_out && $urandom_range(0, 39) == 0) begin
        fl_asid = AW'($urandom); fl_va = {27'($urandom), 12'h0};
        bus.flush_i = 1'b1; bus.flush_asid_i = fl_asid; bus.flush_vaddr_i = fl_va;
        fl_out = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        if (!drain && !pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          pidx[p] = $urandom_range(0, 5);
          pva[p]  = {vpn_of(pidx[p]), 12'($urandom)};
        end
        bus.req_i[p]   = pend[p];
        bus.vaddr_i[p] = pva[p];
      end
      #1;
      bus.tlb_hit_i = 1'b0;
      if (bus.tlb_access_o) begin
        match = 1'b0;
        for (int p = 0; p < 2; p++) if (pend[p] && pva[p] == bus.tlb_vaddr_o) match = 1'b1;
        chk("rnd_lookup_vaddr", 64'(match), 64'd1);
        chk("rnd_lookup_asid", 64'(bus.tlb_asid_o), 64'(asid_run));
        ui = idx_of(bus.tlb_vaddr_o[38:12]);
        if (ui >= 0 && mv[ui]) begin
          bus.tlb_hit_i = 1'b1; bus.tlb_content_i = pte_of(ui);
          bus.tlb_is_2M_i = is2m(ui); bus.tlb_is_1G_i = is1g(ui);
        end
      end
    end
    chk("rnd_drain", 64'({pend[0], pend[1], walk_on, fl_out}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
